mips_mc_control: RTL and testbench

Multi-cycle control sequencer for the MIPS32 core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the register-file write enable, the datapath mux selects and a request/ready handshake to the shared instruction/data memory. It sits between the instruction register and the datapath (register file, ALU, PC), counts retired instructions, and traps on illegal opcodes or memory timeouts.

---
 rtl/mips_mc_control_pkg.sv | 51 +++++
 rtl/mips_mc_control_if.sv | 16 +
 rtl/mips_mc_control_timer.sv | 44 ++++
 rtl/mips_mc_control.sv | 204 ++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mc_control_pkg.sv
//------------------------------------------------------------------------------
// mips_pkg : shared states, opcodes and mux encodings for the MIPS32 control path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADDR  = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC     = 4'd6,
    ST_RWB      = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ADDIEX   = 4'd10,
    ST_ADDIWB   = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] SRCB_DATA2   = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mips_mc_control_if.sv
//------------------------------------------------------------------------------
// mips_mc_control_if : request/ready handshake to the shared instruction/data memory
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mips_mc_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

`default_nettype wire

// File: rtl/mips_mc_control_timer.sv
//------------------------------------------------------------------------------
// mem_handshake_timer : counts unanswered memory-request cycles, flags a timeout
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_handshake_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic timeout
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  assign waiting = req && !ready;
  // Fires on the MEM_TIMEOUT-th consecutive wait cycle.
  assign timeout = waiting && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/mips_mc_control.sv
//------------------------------------------------------------------------------
// mips_mc_control : multi-cycle MIPS32 control sequencer with retire counter and traps
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_mc_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [31:0]       instr,
  input  logic              zero,
  mips_mc_control_if.master mem,
  output logic              iord,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic [3:0]        state,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [CNT_W-1:0]  retired
);
  state_e           state_q, state_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fetch_busy_q, fetch_busy_d;
  logic             req, we, iord_c, handshake, timeout, clear, retire;
  logic             ir_we_c, pc_we_c, reg_write_c, reg_dst_c, mem_to_reg_c, alu_src_a_c;
  logic [1:0]       pc_src_c, alu_src_b_c, alu_op_c;
  logic [5:0]       opcode;
  logic [25:0]      unused_instr;

  assign opcode       = instr[31:26];
  assign unused_instr = instr[25:0];

  // An issued fetch keeps requesting even if run drops before mem_ready.
  always_comb begin
    req    = 1'b0;
    we     = 1'b0;
    iord_c = 1'b0;
    case (state_q)
      ST_FETCH:    req = run || fetch_busy_q;
      ST_MEMREAD:  begin req = 1'b1; iord_c = 1'b1; end
      ST_MEMWRITE: begin req = 1'b1; iord_c = 1'b1; we = 1'b1; end
      default:     ;
    endcase
  end

  assign handshake    = req && mem.mem_ready;
  assign fetch_busy_d = (state_q == ST_FETCH) && req && !mem.mem_ready;

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    retire       = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = PCSRC_ALU;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_DATA2;
    alu_op_c     = ALUOP_ADD;
    case (state_q)
      ST_FETCH: begin
        alu_src_b_c = SRCB_FOUR;
        if (handshake) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b_c = SRCB_IMM_SL2;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADDR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default: begin
            state_d      = ST_TRAP;
            trap_cause_d = TRAP_ILLEGAL;
          end
        endcase
      end
      ST_MEMADDR, ST_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        if (state_q == ST_ADDIEX) state_d = ST_ADDIWB;
        else state_d = (opcode == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: if (handshake) state_d = ST_MEMWB;
      ST_MEMWRITE: begin
        if (handshake) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire       = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_FUNCT;
        state_d     = ST_RWB;
      end
      ST_RWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_ADDIWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = ALUOP_SUB;
        pc_we_c     = zero;
        pc_src_c    = PCSRC_ALUOUT;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we_c  = 1'b1;
        pc_src_c = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      default: ;
    endcase
    if (timeout) begin
      state_d      = ST_TRAP;
      trap_cause_d = TRAP_TIMEOUT;
    end
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  // Every state change restarts the wait count for the state being entered.
  assign clear = (state_d != state_q);

  mem_handshake_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .ready  (mem.mem_ready),
    .clear  (clear),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      trap_cause_q <= TRAP_NONE;
      retired_q    <= '0;
      fetch_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      retired_q    <= retired_d;
      fetch_busy_q <= fetch_busy_d;
    end
  end

  // Gating with rst_n keeps every strobe low for the whole reset window.
  assign mem.mem_req = rst_n && req;
  assign mem.mem_we  = rst_n && we;
  assign iord        = rst_n && iord_c;
  assign ir_we       = rst_n && ir_we_c;
  assign pc_we       = rst_n && pc_we_c;
  assign pc_src      = rst_n ? pc_src_c : 2'd0;
  assign reg_write   = rst_n && reg_write_c;
  assign reg_dst     = rst_n && reg_dst_c;
  assign mem_to_reg  = rst_n && mem_to_reg_c;
  assign alu_src_a   = rst_n && alu_src_a_c;
  assign alu_src_b   = rst_n ? alu_src_b_c : 2'd0;
  assign alu_op      = rst_n ? alu_op_c : 2'd0;
  assign state       = state_q;
  assign trap        = (state_q == ST_TRAP);
  assign trap_cause  = trap_cause_q;
  assign retired     = retired_q;
endmodule

`default_nettype wire

// File: tb/tb_mips_mc_control.sv
//------------------------------------------------------------------------------
// tb_mips_mc_control : directed self-checking bench for the multi-cycle control FSM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_mc_control;
  import mips_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_ADDI = 32'h21080005;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst_n, run, zero;
  logic [31:0] instr;
  logic        iord, ir_we, pc_we, reg_write, reg_dst, mem_to_reg, alu_src_a, trap;
  logic [1:0]  pc_src, alu_src_b, alu_op, trap_cause;
  logic [3:0]  state;
  logic [31:0] retired;
  int          checks = 0;
  int          errors = 0;

  mips_mc_control_if mem_if ();

  mips_mc_control #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero), .mem(mem_if),
    .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; zero = 1'b0; instr = '0; mem_if.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; zero = 1'b0; instr = '0; mem_if.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_if.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req: got %0b expected 0", mem_if.mem_req);
    end
    checks++;
    if ({ir_we, pc_we, iord, alu_src_b, reg_write, alu_op} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
                         {ir_we, pc_we, iord, alu_src_b, reg_write, alu_op});
    end
    checks++;
    if ({state, trap, trap_cause} !== 7'b0 || retired !== 32'd0) begin
      errors++; $display("FAIL reset_state: got state=%0d trap=%0b cause=%0d retired=%0d expected all 0",
                         state, trap, trap_cause, retired);
    end
    // mem_ready while no request is pending must not advance the FSM
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst_n = 1'b1; run = 1'b0; mem_if.mem_ready = 1'b1; #1;
      checks++;
      if (state !== ST_FETCH || ir_we !== 1'b0 || mem_if.mem_req !== 1'b0) begin
        errors++; $display("FAIL idle_ready_ignored: got state=%0d ir_we=%0b req=%0b expected 0/0/0",
                           state, ir_we, mem_if.mem_req);
      end
    end
  endtask

  task automatic test_rtype();
    state_e exp_st [4];
    int     wr_cnt;
    exp_st = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_RWB};
    wr_cnt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); run = (i == 0); mem_if.mem_ready = 1'b1; instr = I_ADD; #1;
      checks++;
      if (state !== exp_st[i]) begin
        errors++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
      end
      if (reg_write === 1'b1) wr_cnt++;
      if (i == 0) begin
        checks++;
        if ({mem_if.mem_req, ir_we, pc_we, pc_src, alu_src_b} !== 7'b1110001) begin
          errors++; $display("FAIL rtype_fetch_ctrl: got %b expected 1110001",
                             {mem_if.mem_req, ir_we, pc_we, pc_src, alu_src_b});
        end
      end
      if (i == 2) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b10010) begin
          errors++; $display("FAIL rtype_exec_ctrl: got %b expected 10010", {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (i == 3) begin
        checks++;
        if (reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
          errors++; $display("FAIL rtype_rwb_sel: got reg_dst=%0b mem_to_reg=%0b expected 1/0", reg_dst, mem_to_reg);
        end
      end
    end
    @(negedge clk); run = 1'b0; #1;
    checks++;
    if (wr_cnt !== 1 || retired !== 32'd1 || state !== ST_FETCH) begin
      errors++; $display("FAIL rtype_retire: got writes=%0d retired=%0d state=%0d expected 1/1/0",
                         wr_cnt, retired, state);
    end
  endtask

  task automatic test_lw_wait();
    state_e     exp_st [11];
    logic [1:0] exp_mi;
    int         wr_cnt;
    exp_st = '{ST_FETCH, ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_MEMADDR,
               ST_MEMREAD, ST_MEMREAD, ST_MEMREAD, ST_MEMREAD, ST_MEMWB};
    wr_cnt = 0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      // run drops after the fetch is issued; the request must still complete
      @(negedge clk); run = (i == 0); mem_if.mem_ready = (i == 3 || i == 9); instr = I_LW; #1;
      exp_mi = {(i <= 3) || (i >= 6 && i <= 9), (i >= 6 && i <= 9)};
      checks++;
      if (state !== exp_st[i] || {mem_if.mem_req, iord} !== exp_mi) begin
        errors++; $display("FAIL lw_cycle[%0d]: got state=%0d req/iord=%b expected state=%0d req/iord=%b",
                           i, state, {mem_if.mem_req, iord}, exp_st[i], exp_mi);
      end
      if (reg_write === 1'b1) begin
        wr_cnt++;
        checks++;
        if (mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
          errors++; $display("FAIL lw_wb_sel: got mem_to_reg=%0b reg_dst=%0b expected 1/0", mem_to_reg, reg_dst);
        end
      end
    end
    @(negedge clk); run = 1'b0; mem_if.mem_ready = 1'b0; #1;
    checks++;
    if (wr_cnt !== 1 || retired !== 32'd1 || state !== ST_FETCH) begin
      errors++; $display("FAIL lw_retire: got writes=%0d retired=%0d state=%0d expected 1/1/0",
                         wr_cnt, retired, state);
    end
  endtask

  task automatic test_beq();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); run = (i == 0); mem_if.mem_ready = 1'b1; zero = (k == 0); instr = I_BEQ; #1;
        if (i == 2) begin
          checks++;
          if (state !== ST_BRANCH || pc_we !== (k == 0) || pc_src !== 2'd1 || alu_op !== 2'd1) begin
            errors++; $display("FAIL beq_branch[z=%0d]: got state=%0d pc_we=%0b pc_src=%0d alu_op=%0d expected %0d/%0b/1/1",
                               (k == 0), state, pc_we, pc_src, alu_op, ST_BRANCH, (k == 0));
          end
        end
      end
      @(negedge clk); run = 1'b0; #1;
      checks++;
      if (retired !== 32'(k + 1) || state !== ST_FETCH) begin
        errors++; $display("FAIL beq_retire[%0d]: got retired=%0d state=%0d expected %0d/0", k, retired, state, k + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    state_e exp_st [11];
    exp_st = '{ST_FETCH, ST_DECODE, ST_ADDIEX, ST_ADDIWB,
               ST_FETCH, ST_DECODE, ST_MEMADDR, ST_MEMWRITE,
               ST_FETCH, ST_DECODE, ST_JUMP};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); run = 1'b1; mem_if.mem_ready = 1'b1;
      instr = (i < 4) ? I_ADDI : (i < 8) ? I_SW : I_J; #1;
      checks++;
      if (state !== exp_st[i]) begin
        errors++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
      end
      if (exp_st[i] == ST_ADDIEX || exp_st[i] == ST_MEMADDR) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b11000) begin
          errors++; $display("FAIL b2b_addr_ctrl[%0d]: got %b expected 11000", i, {alu_src_a, alu_src_b, alu_op});
        end
      end
      if (exp_st[i] == ST_ADDIWB) begin
        checks++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
          errors++; $display("FAIL b2b_addiwb: got %b expected 100", {reg_write, reg_dst, mem_to_reg});
        end
      end
      if (exp_st[i] == ST_MEMWRITE) begin
        checks++;
        if ({mem_if.mem_req, mem_if.mem_we, iord, reg_write} !== 4'b1110) begin
          errors++; $display("FAIL b2b_memwrite: got %b expected 1110", {mem_if.mem_req, mem_if.mem_we, iord, reg_write});
        end
      end
      if (exp_st[i] == ST_JUMP) begin
        checks++;
        if (pc_we !== 1'b1 || pc_src !== 2'd2) begin
          errors++; $display("FAIL b2b_jump: got pc_we=%0b pc_src=%0d expected 1/2", pc_we, pc_src);
        end
      end
    end
    @(negedge clk); run = 1'b0; #1;
    checks++;
    if (retired !== 32'd3 || state !== ST_FETCH) begin
      errors++; $display("FAIL b2b_retire: got retired=%0d state=%0d expected 3/0", retired, state);
    end
  endtask

  task automatic test_reset_mid();
    // starts from the back-to-back run, so retired is non-zero before reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); run = (i == 0); mem_if.mem_ready = (i == 0); instr = I_LW; #1;
    end
    checks++;
    if (state !== ST_MEMREAD || mem_if.mem_req !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got state=%0d req=%0b expected %0d/1", state, mem_if.mem_req, ST_MEMREAD);
    end
    rst_n = 1'b0; run = 1'b1; #1;
    checks++;
    if ({mem_if.mem_req, iord, ir_we, pc_we, reg_write, alu_src_b} !== 7'b0 || state !== ST_FETCH || retired !== 32'd0) begin
      errors++; $display("FAIL rstmid_async: got ctrl=%b state=%0d retired=%0d expected 0/0/0",
                         {mem_if.mem_req, iord, ir_we, pc_we, reg_write, alu_src_b}, state, retired);
    end
    @(negedge clk); rst_n = 1'b1; run = 1'b0; mem_if.mem_ready = 1'b0; #1;
    checks++;
    if (state !== ST_FETCH || retired !== 32'd0 || mem_if.mem_req !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: got state=%0d retired=%0d req=%0b expected 0/0/0",
                         state, retired, mem_if.mem_req);
    end
  endtask

  task automatic test_illegal();
    state_e exp_st [7];
    int     req_cnt;
    exp_st = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_RWB, ST_FETCH, ST_DECODE, ST_TRAP};
    req_cnt = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); run = 1'b1; mem_if.mem_ready = 1'b1; instr = (i < 4) ? I_ADD : I_ILL; #1;
      checks++;
      if (state !== exp_st[i]) begin
        errors++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state, exp_st[i]);
      end
    end
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd1) begin
      errors++; $display("FAIL illegal_trap: got trap=%0b cause=%0d expected 1/1", trap, trap_cause);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); run = 1'b1; mem_if.mem_ready = 1'b1; #1;
      if (mem_if.mem_req === 1'b1) req_cnt++;
    end
    checks++;
    if (req_cnt !== 0 || retired !== 32'd1 || state !== ST_TRAP || trap !== 1'b1) begin
      errors++; $display("FAIL illegal_frozen: got reqs=%0d retired=%0d state=%0d trap=%0b expected 0/1/%0d/1",
                         req_cnt, retired, state, trap, ST_TRAP);
    end
  endtask

  task automatic test_timeout();
    state_e exp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); run = (i == 0); mem_if.mem_ready = (i == 0); instr = I_SW; #1;
      exp = (i == 0) ? ST_FETCH : (i == 1) ? ST_DECODE : (i == 2) ? ST_MEMADDR :
            (i < 19) ? ST_MEMWRITE : ST_TRAP;
      checks++;
      if (state !== exp || mem_if.mem_req !== (exp == ST_MEMWRITE || exp == ST_FETCH)) begin
        errors++; $display("FAIL timeout_cycle[%0d]: got state=%0d req=%0b expected state=%0d",
                           i, state, mem_if.mem_req, exp);
      end
    end
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'd2 || retired !== 32'd0) begin
      errors++; $display("FAIL timeout_trap: got trap=%0b cause=%0d retired=%0d expected 1/2/0",
                         trap, trap_cause, retired);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1);
  end
endmodule

`default_nettype wire
